// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and bit-count constants for the multiplier sequencer.
package mult_pkg;
    localparam int N_BITS = 8;
    localparam int CNT_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
    typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;
endpackage

// File: rtl/run_edge_sync.sv
// run_edge_sync: optional 2-flop synchronizer (RUN_SYNC_EN) followed by rising-edge detection.
// RESET_VAL seeds every flop so a level held through reset does not look like an edge.
module run_edge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);
`ifdef RUN_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge Clk) sync_q <= Reset ? {2{RESET_VAL}} : {sync_q[0], d_i};
    assign level_o = sync_q[1];
`else
    assign level_o = d_i;
`endif
    logic prev_q;
    always_ff @(posedge Clk) prev_q <= Reset ? RESET_VAL : level_o;
    assign rise_o = level_o & ~prev_q;
endmodule

// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer: control FSM for an 8-bit add/shift multiplier (subtract on the final bit).
// Define RUN_SYNC_EN to synchronize Run and ClearA_LoadB through run_edge_sync.
module multiplier_sequencer
    import mult_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Load_B,
    output logic Clear_XA,
    output logic Compute,
    output logic Fn,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic run_lvl, run_rise, clr_lvl, clr_rise_unused, idle_load;

    // Run seeds high so a Run held through reset cannot start a multiply.
    run_edge_sync #(.RESET_VAL(1'b1)) u_run (
        .Clk(Clk), .Reset(Reset), .d_i(Run), .level_o(run_lvl), .rise_o(run_rise)
    );
    run_edge_sync #(.RESET_VAL(1'b0)) u_clr (
        .Clk(Clk), .Reset(Reset), .d_i(ClearA_LoadB), .level_o(clr_lvl), .rise_o(clr_rise_unused)
    );

    always_ff @(posedge Clk) begin
        state_q <= Reset ? IDLE : state_d;
        cnt_q   <= Reset ? '0 : cnt_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = run_rise ? CLEAR : IDLE;
            CLEAR: begin
                state_d = ADD;
                cnt_d   = '0;
            end
            ADD:   state_d = SHIFT;
            SHIFT: begin
                state_d = (cnt_q == CNT_LAST) ? HOLD : ADD;
                cnt_d   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
            end
            HOLD:  state_d = run_lvl ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A Run edge in IDLE takes priority over the load request.
    always_comb begin
        idle_load = (state_q == IDLE) && clr_lvl && !run_rise;
        Load_B    = !Reset && idle_load;
        Clear_XA  = !Reset && (idle_load || state_q == CLEAR);
        Compute   = !Reset && state_q == ADD && M;
        Fn        = !Reset && state_q == ADD && cnt_q == CNT_LAST;
        Shift_En  = !Reset && state_q == SHIFT;
        Busy      = !Reset && (state_q == CLEAR || state_q == ADD || state_q == SHIFT);
        Done      = !Reset && state_q == HOLD;
    end
endmodule

// File: tb/tb_multiplier_sequencer.sv
// tb_multiplier_sequencer: directed and random runs checked against a cycle-position model.
module tb_multiplier_sequencer;
    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Load_B, Clear_XA, Compute, Fn, Shift_En, Busy, Done;
    int n_chk = 0, n_fail = 0;
    int t = 0;
    logic run_prev = 1'b1;
    logic [7:0] b_val = 8'h00;
    int n_comp = 0, n_comp_fn = 0;

    always #5 Clk = ~Clk;

    multiplier_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Load_B(Load_B), .Clear_XA(Clear_XA), .Compute(Compute), .Fn(Fn),
        .Shift_En(Shift_En), .Busy(Busy), .Done(Done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // t = cycles since the Run edge: 0 idle, 1 clear, even 2..16 add, odd 3..17 shift, 18 hold.
    task automatic cycle(input logic rst, input logic run, input logic clr);
        logic rise;
        logic [6:0] exp;
        @(negedge Clk);
        Reset = rst;
        Run = run;
        ClearA_LoadB = clr;
        M = (t >= 2 && t <= 16 && t % 2 == 0) ? b_val[(t - 2) / 2] : 1'($urandom_range(1));
        #1;
        rise = run & ~run_prev;
        exp = '0;
        if (!rst) begin
            if (t == 0) exp[6:5] = {2{clr & ~rise}};
            else if (t == 1) exp = 7'b0100010;
            else if (t <= 17 && t % 2 == 0) exp = {2'b00, M, t == 16, 3'b010};
            else if (t <= 17) exp = 7'b0000110;
            else exp = 7'b0000001;
        end
        check($sformatf("outputs t=%0d", t),
              int'({Load_B, Clear_XA, Compute, Fn, Shift_En, Busy, Done}), int'(exp));
        if (Compute) begin
            n_comp++;
            if (Fn) n_comp_fn++;
        end
        @(posedge Clk);
        if (rst) begin
            t = 0;
            run_prev = 1'b1;
        end else begin
            t = (t == 0) ? (rise ? 1 : 0) : (t < 18) ? t + 1 : (run ? 18 : 0);
            run_prev = run;
        end
    endtask

    task automatic do_run(input logic [7:0] b, input int high_cycles, input logic clr_noise);
        b_val = b;
        n_comp = 0;
        n_comp_fn = 0;
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < high_cycles; i++)
            cycle(1'b0, 1'b1, clr_noise & (t != 0) & 1'($urandom_range(1)));
        for (int i = 0; i < 40 && t != 0; i++)
            cycle(1'b0, 1'b0, clr_noise & (t != 0) & 1'($urandom_range(1)));
    endtask

    initial begin
        Reset = 1'b1;
        Run = 1'b1;
        ClearA_LoadB = 1'b0;
        M = 1'b0;
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40 && t != 0; i++) cycle(1'b0, 1'b0, 1'b0);

        do_run(8'h07, 1, 1'b0);
        check("b07_computes", n_comp, 3);
        check("b07_fn_computes", n_comp_fn, 0);
        do_run(8'h80, 3, 1'b1);
        check("b80_computes", n_comp, 1);
        check("b80_fn_computes", n_comp_fn, 1);
        do_run(8'h5A, 40, 1'b1);
        check("held_run_computes", n_comp, 4);

        b_val = 8'hFF;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30 && t != 9; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        do_run(8'hC3, 2, 1'b0);
        check("after_reset_computes", n_comp, 4);

        for (int r = 0; r < 8; r++) begin
            logic [7:0] b;
            b = 8'($urandom);
            do_run(b, $urandom_range(1, 25), 1'b1);
            check($sformatf("rand_computes b=%0h", b), n_comp, $countones(b));
            check($sformatf("rand_fn_computes b=%0h", b), n_comp_fn, int'(b[7]));
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier_sequencer.md
MULTIPLIER_SEQUENCER -- requirements
Module: multiplier_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port Run, input, 1, start request; only a rising edge starts a multiply.
REQ-004 SHALL have port ClearA_LoadB, input, 1, level; loads multiplier B and clears X/A while idle.
REQ-005 SHALL have port M, input, 1, current LSB of B from the datapath.
REQ-006 SHALL have port Load_B, output, 1, loads B from switches.
REQ-007 SHALL have port Clear_XA, output, 1, clears X and A.
REQ-008 SHALL have port Compute, output, 1, loads A from the adder and X from the adder sign bit.
REQ-009 SHALL have port Fn, output, 1, adder function: 0 = add, 1 = subtract.
REQ-010 SHALL have port Shift_En, output, 1, arithmetic right shift of X:A:B.
REQ-011 SHALL have port Busy, output, 1, high from CLEAR through SHIFT7.
REQ-012 SHALL have port Done, output, 1, high in HOLD.

Function
REQ-013 SHALL implement states IDLE, CLEAR, ADD, SHIFT and HOLD, plus a 3-bit bit counter cnt.
REQ-014 SHALL detect a Run edge as Run & ~Run_q, where Run_q is Run registered.
REQ-015 In IDLE, a Run edge SHALL go to CLEAR; otherwise the FSM SHALL stay in IDLE.
REQ-016 CLEAR SHALL last 1 cycle with Clear_XA=1, set cnt=0, and go to ADD.
REQ-017 ADD SHALL last 1 cycle: Compute=M, and Fn=1 iff cnt==7, else Fn=0; next state SHIFT.
REQ-018 SHIFT SHALL last 1 cycle with Shift_En=1: if cnt==7 go to HOLD, else cnt+1 and go to ADD.
REQ-019 The FSM SHALL always spend 2 cycles per bit regardless of M, for a fixed 17-cycle Busy window.
REQ-020 HOLD SHALL keep Done=1 until Run==0, then go to IDLE; Run held high SHALL never retrigger.
REQ-021 In IDLE with ClearA_LoadB=1 and no Run edge, Load_B=1 and Clear_XA=1 SHALL be asserted every cycle held.
REQ-022 If a Run edge and ClearA_LoadB=1 occur in the same cycle in IDLE, Run SHALL win and Load_B SHALL stay 0.
REQ-023 ClearA_LoadB and Run edges SHALL be ignored outside IDLE.
REQ-024 Compute, Shift_En, Load_B and Clear_XA SHALL be mutually exclusive in every cycle except REQ-021.
REQ-025 Outputs SHALL be decoded from the state, except Compute, which also depends on M.

Reset
REQ-026 Reset SHALL force IDLE, cnt=0 and Run_q=1 on the next edge, from any state including mid-run.
REQ-027 During and immediately after Reset, all outputs SHALL be 0.
REQ-028 Because Run_q resets to 1, Run held high through Reset SHALL NOT start a run.

Configuration
REQ-029 With RUN_SYNC_EN defined, Run and ClearA_LoadB SHALL each pass through a 2-flop synchronizer before use, adding 2 cycles input latency.
REQ-030 With RUN_SYNC_EN defined, the Run synchronizer SHALL reset to 1 and the ClearA_LoadB synchronizer to 0.
REQ-031 Without RUN_SYNC_EN, the inputs SHALL be used directly; all other behaviour is identical.

Structure
REQ-032 Package mult_pkg SHALL hold the state enum type and the constant N_BITS=8; the cnt terminal value SHALL be N_BITS-1.
REQ-033 Synchronization plus edge detection SHALL live in one sub-module, run_edge_sync, instantiated per input; the FSM stays in the top.

Verification (RUN_SYNC_EN undefined; Run edge sampled at edge E)
REQ-034 Run edge at edge E -> Clear_XA=1 in cycle E+1, Busy=1 in cycles E+1..E+17, Done=1 from cycle E+18.
REQ-035 M sequence 1,1,1,0,0,0,0,0 (B=0x07) -> Compute=1 only in ADD for cnt 0,1,2, with Fn=0 each time.
REQ-036 B=0x80 (M=1 only at cnt 7) -> exactly one Compute, in ADD with cnt=7 and Fn=1.
REQ-037 Run held high for 40 cycles -> exactly one run, Done held until Run=0, then IDLE the next cycle.
REQ-038 Reset asserted in SHIFT with cnt=3 -> next cycle IDLE, all outputs 0; a new Run edge gives a full 17-cycle run.
REQ-039 ClearA_LoadB=1 for 3 cycles in IDLE -> Load_B=1 and Clear_XA=1 for 3 cycles; pulsed while Busy -> Load_B stays 0.
